// File: rtl/mem_pkg.sv
// mem_pkg: MemOP encodings, responder FSM states and byte-enable helper
package mem_pkg;
  localparam logic [2:0] MOP_B  = 3'b000;
  localparam logic [2:0] MOP_H  = 3'b001;
  localparam logic [2:0] MOP_W  = 3'b010;
  localparam logic [2:0] MOP_BU = 3'b100;
  localparam logic [2:0] MOP_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  function automatic logic [3:0] be_mask(input logic [2:0] memop, input logic [1:0] a);
    be_mask = memop[1] ? 4'b1111 : memop[0] ? (a[1] ? 4'b1100 : 4'b0011) : 4'b0001 << a;
  endfunction
endpackage

// File: rtl/mem_lane_fmt.sv
// mem_lane_fmt: lane select and sign/zero extension of load data, plus misalign/illegal-op flag
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  a,
  input  logic [2:0]  memop,
  input  logic        wr,
  output logic [31:0] data,
  output logic        bad
);
  logic [31:0] sh;
  logic ill, mis;
  always_comb begin
    sh = word >> {a, 3'b000};
    ill = memop == 3'b011 || memop[2:1] == 2'b11 || (wr && memop[2]);
    mis = memop[0] ? a[0] : (memop[1] && a != 2'b00);
    bad = ill || mis;
    data = memop[1] ? sh
         : memop[0] ? {{16{~memop[2] & sh[15]}}, sh[15:0]}
         : {{24{~memop[2] & sh[7]}}, sh[7:0]};
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with programmable wait states
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wr,
  input  logic [2:0]  req_memop,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state, state_n;
  logic [3:0] cnt;
  logic [31:0] addr_q, wdata_q, a_addr, a_wdata, wsh, word, fmt_data;
  logic [2:0] memop_q, a_op;
  logic wr_q, a_wr, accept, commit, range_err, fmt_bad, err;
  logic [3:0] be;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH_WORDS];
  // with zero latency the access commits on the accept edge, straight from the request inputs
  always_comb begin
    accept = state == IDLE && req_valid;
    commit = (accept && LATENCY == 0) || (state == WAIT && cnt == 4'd1);
    a_addr = state == IDLE ? req_addr : addr_q;
    a_wdata = state == IDLE ? req_wdata : wdata_q;
    a_op = state == IDLE ? req_memop : memop_q;
    a_wr = state == IDLE ? req_wr : wr_q;
    idx = a_addr[AW+1:2];
    range_err = |a_addr[31:AW+2];
    err = range_err || fmt_bad;
    be = be_mask(a_op, a_addr[1:0]);
    wsh = a_wdata << {a_addr[1:0], 3'b000};
    word = mem[idx];
  end
  mem_lane_fmt u_fmt (
    .word (word),
    .a    (a_addr[1:0]),
    .memop(a_op),
    .wr   (a_wr),
    .data (fmt_data),
    .bad  (fmt_bad)
  );
  always_ff @(posedge clk)
    if (commit && a_wr && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wsh[8*i +: 8];
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE ? (req_valid ? (LATENCY == 0 ? RESP : WAIT) : IDLE)
            : state == WAIT ? (cnt == 4'd1 ? RESP : WAIT)
            : (rsp_ready ? IDLE : RESP);
  end
  always_comb begin
    req_ready = state == IDLE;
    rsp_valid = state == RESP;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      memop_q <= '0;
      wr_q <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= req_addr;
        wdata_q <= req_wdata;
        memop_q <= req_memop;
        wr_q <= req_wr;
        cnt <= 4'(LATENCY);
      end else if (state == WAIT) cnt <= cnt - 4'd1;
      if (commit) begin
        rsp_rdata <= (err || a_wr) ? '0 : fmt_data;
        rsp_err <= err;
      end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: random and directed checks of two builds (LATENCY 2 / depth 1024, LATENCY 0 / depth 64)
module tb_mem_responder;
  logic clk = 1'b0;
  logic [1:0] rst, req_valid, req_ready, req_wr, rsp_valid, rsp_ready, rsp_err;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0][2:0] req_memop;
  int checks = 0, errors = 0;
  bit [31:0] ref_mem [2][1024];
  always #5 clk = ~clk;
  mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_wr(req_wr[0]), .req_memop(req_memop[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );
  mem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_wr(req_wr[1]), .req_memop(req_memop[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic void model(input int d, input bit wr, input bit [2:0] op, input bit [31:0] a,
                                input bit [31:0] wd, output bit err, output bit [31:0] rd);
    int unsigned depth = d == 0 ? 1024 : 64;
    int unsigned idx = a >> 2;
    int lane = int'(a & 3);
    int sz = op[1] ? 4 : op[0] ? 2 : 1;
    bit [31:0] w;
    err = !(op inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) || (wr && op[2]) ||
          idx >= depth || lane % sz != 0;
    rd = 0;
    if (err) return;
    w = ref_mem[d][idx];
    if (wr) begin
      for (int k = 0; k < sz; k++) w[8*(lane+k) +: 8] = wd[8*k +: 8];
      ref_mem[d][idx] = w;
      return;
    end
    rd = w >> (8 * lane);
    if (sz == 1) rd = (op[2] || !rd[7]) ? rd & 32'hFF : rd | 32'hFFFFFF00;
    if (sz == 2) rd = (op[2] || !rd[15]) ? rd & 32'hFFFF : rd | 32'hFFFF0000;
  endfunction
  task automatic xact(input int d, input bit wr, input bit [2:0] op, input bit [31:0] a,
                      input bit [31:0] wd, input int stall, output logic [31:0] got, output logic gerr);
    bit e;
    bit [31:0] r;
    int n;
    int lat = d == 0 ? 2 : 0;
    req_valid[d] = 1'b1;
    req_wr[d] = wr;
    req_memop[d] = op;
    req_addr[d] = a;
    req_wdata[d] = wd;
    chk("ready_idle", 32'(req_ready[d]), 1);
    @(posedge clk); #1;
    req_valid[d] = 1'($urandom);
    req_wr[d] = 1'($urandom);
    req_memop[d] = 3'($urandom);
    req_addr[d] = $urandom;
    req_wdata[d] = $urandom;
    model(d, wr, op, a, wd, e, r);
    n = 1;
    while (!rsp_valid[d] && n < 40) begin
      chk("ready_busy", 32'(req_ready[d]), 0);
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, lat + 1);
    for (int i = 0; i <= stall; i++) begin
      chk("rsp_valid", 32'(rsp_valid[d]), 1);
      chk("ready_resp", 32'(req_ready[d]), 0);
      chk("rdata", rsp_rdata[d], r);
      chk("err", 32'(rsp_err[d]), 32'(e));
      if (i < stall) begin @(posedge clk); #1; end
    end
    got = rsp_rdata[d];
    gerr = rsp_err[d];
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    chk("valid_drop", 32'(rsp_valid[d]), 0);
  endtask
  initial begin
    logic [31:0] g;
    logic ge;
    bit [31:0] a;
    rst = 2'b11;
    req_valid = '0;
    rsp_ready = '0;
    req_wr = '0;
    req_addr = '0;
    req_wdata = '0;
    req_memop = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", 32'(rsp_valid[d]), 0);
      chk("rst_rdata", rsp_rdata[d], 0);
      chk("rst_err", 32'(rsp_err[d]), 0);
      chk("rst_ready", 32'(req_ready[d]), 1);
    end
    rst = 2'b00;
    xact(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, g, ge);
    xact(0, 0, 3'b010, 32'h100, 0, 0, g, ge);
    chk("dir_word", g, 32'hDEADBEEF);
    xact(0, 1, 3'b000, 32'h103, 32'h80, 0, g, ge);
    xact(0, 0, 3'b000, 32'h103, 0, 0, g, ge);
    chk("dir_lb", g, 32'hFFFFFF80);
    xact(0, 0, 3'b100, 32'h103, 0, 0, g, ge);
    chk("dir_lbu", g, 32'h00000080);
    xact(0, 0, 3'b010, 32'h100, 0, 0, g, ge);
    chk("dir_merge", g, 32'h80ADBEEF);
    xact(0, 0, 3'b001, 32'h102, 0, 0, g, ge);
    chk("dir_lh", g, 32'hFFFF80AD);
    xact(0, 0, 3'b101, 32'h102, 0, 0, g, ge);
    chk("dir_lhu", g, 32'h000080AD);
    xact(0, 0, 3'b001, 32'h101, 0, 0, g, ge);
    chk("dir_mis_h", {31'b0, ge}, 1);
    xact(0, 1, 3'b010, 32'h102, 32'h12345678, 0, g, ge);
    chk("dir_mis_sw", {31'b0, ge}, 1);
    xact(0, 1, 3'b100, 32'h100, 32'h55, 0, g, ge);
    chk("dir_ill_st", {31'b0, ge}, 1);
    xact(0, 0, 3'b010, 32'h100, 0, 5, g, ge);
    chk("dir_unchanged", g, 32'h80ADBEEF);
    xact(0, 0, 3'b010, 32'h1000, 0, 0, g, ge);
    chk("dir_range", {31'b0, ge}, 1);
    xact(0, 1, 3'b010, 32'h200, 32'h11111111, 0, g, ge);
    xact(0, 0, 3'b010, 32'h200, 0, 0, g, ge);
    req_valid[0] = 1'b1;
    req_wr[0] = 1'b1;
    req_memop[0] = 3'b010;
    req_addr[0] = 32'h200;
    req_wdata[0] = 32'h22222222;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    #2 rst[0] = 1'b1;
    #1;
    chk("arst_valid", 32'(rsp_valid[0]), 0);
    chk("arst_rdata", rsp_rdata[0], 0);
    chk("arst_err", 32'(rsp_err[0]), 0);
    chk("arst_ready", 32'(req_ready[0]), 1);
    repeat (3) @(posedge clk);
    #1 rst[0] = 1'b0;
    xact(0, 0, 3'b010, 32'h200, 0, 0, g, ge);
    chk("abort_store", g, 32'h11111111);
    xact(1, 0, 3'b010, 32'h100, 0, 0, g, ge);
    chk("dir_range0", {31'b0, ge}, 1);
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) xact(d, 1, 3'b010, 32'(4 * w), $urandom, 0, g, ge);
      for (int t = 0; t < 150; t++) begin
        a = ($urandom_range(0, 7) == 0) ? ($urandom | (d == 0 ? 32'h1000 : 32'h100)) : 32'($urandom_range(0, 63));
        xact(d, 1'($urandom), 3'($urandom), a, $urandom, int'($urandom_range(0, 2)), g, ge);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
